booth_product_normalizer: RTL and testbench

Pipelined downstream stage of the Booth/Wallace mantissa multiplier. It takes the redundant sum/carry pair and sign-extension suppression flag from the Wallace tree and resolves the pair with a two-stage split carry-propagate adder. It then normalizes the 2·(PARM_MANT+1)-bit product to a (PARM_MANT+1)-bit significand with round and sticky bits, and delivers the result to the rounding stage over a valid/ready handshake.

---
 rtl/booth_product_normalizer.sv | 144 ++++++++++++++
 tb/tb_booth_product_normalizer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_product_normalizer.sv
// Resolves the Wallace tree sum/carry pair with a split two-stage adder, then
// normalizes the product to a significand plus round/sticky over valid/ready.
module booth_product_normalizer #(
  parameter int PARM_MANT = 23,
  parameter int PARM_TAG  = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [2*PARM_MANT+2:0] wallace_sum_i,
  input  logic [2*PARM_MANT+2:0] wallace_carry_i,
  input  logic                   suppression_sign_extension_i,
  input  logic [PARM_TAG-1:0]    tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [PARM_MANT:0]     mant_o,
  output logic                   round_o,
  output logic                   sticky_o,
  output logic                   exp_inc_o,
  output logic                   zero_o,
  output logic                   sext_o,
  output logic [PARM_TAG-1:0]    tag_o
);

  localparam int W = 2*PARM_MANT + 3;  // tree vector width
  localparam int L = PARM_MANT + 1;    // low adder width
  localparam int U = W - 1 - L;        // upper adder width
  localparam int M = PARM_MANT;

  // Handshake
  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, accept, s1_move;

  assign s2_adv     = !s2_valid || out_ready_i;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready_o = s1_adv;
  assign accept     = in_valid_i && s1_adv && !flush_i;
  assign s1_move    = s1_valid && s2_adv && !flush_i;
  assign out_valid_o = s2_valid;

  // Stage 1: low-half add. Bit W-1 of sum and bit W-2 of carry fall outside
  // the modulus once the carry is doubled, so they never reach the adders.
  logic [W-2:0] carry_sh;
  logic [L:0]   lo_add;
  logic         unused_artifact;

  assign carry_sh        = {wallace_carry_i[W-3:0], 1'b0};
  assign lo_add          = {1'b0, wallace_sum_i[L-1:0]} + {1'b0, carry_sh[L-1:0]};
  assign unused_artifact = ^{wallace_sum_i[W-1], wallace_carry_i[W-2]};

  logic [L-1:0]        s1_lo;
  logic                s1_c1;
  logic                s1_stk_lo;
  logic [U-1:0]        s1_sum_hi;
  logic [U-1:0]        s1_car_hi;
  logic                s1_sext;
  logic [PARM_TAG-1:0] s1_tag;

  always_ff @(posedge clk_i) begin
    // NOTE: data registers are cleared on reset as well as the valids, so every
    // output reads zero right after reset instead of stale or X payload.
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_c1     <= 1'b0;
      s1_stk_lo <= 1'b0;
      s1_sum_hi <= '0;
      s1_car_hi <= '0;
      s1_sext   <= 1'b0;
      s1_tag    <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept || (s1_valid && !s2_adv);
      if (accept) begin
        s1_lo     <= lo_add[L-1:0];
        s1_c1     <= lo_add[L];
        s1_stk_lo <= |lo_add[M-1:0];
        s1_sum_hi <= wallace_sum_i[W-2:L];
        s1_car_hi <= carry_sh[W-2:L];
        s1_sext   <= suppression_sign_extension_i;
        s1_tag    <= tag_i;
      end
    end
  end

  // Stage 2: upper add with the low carry-out, then the one-bit normalize mux.
  logic [U-1:0]   hi_sum;
  logic [W-2:0]   product;
  logic [M:0]     n_mant;
  logic           n_round, n_sticky, n_exp_inc, n_zero;

  assign hi_sum  = s1_sum_hi + s1_car_hi + U'(s1_c1);
  assign product = {hi_sum, s1_lo};

  always_comb begin
    n_mant    = '0;
    n_round   = 1'b0;
    n_sticky  = 1'b0;
    n_exp_inc = 1'b0;
    n_zero    = (product == '0);
    if (!n_zero) begin
      if (product[2*M+1]) begin
        n_mant    = product[2*M+1:M+1];
        n_round   = product[M];
        n_sticky  = s1_stk_lo;
        n_exp_inc = 1'b1;
      end else begin
        n_mant    = product[2*M:M];
        n_round   = product[M-1];
        n_sticky  = |product[M-2:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid  <= 1'b0;
      mant_o    <= '0;
      round_o   <= 1'b0;
      sticky_o  <= 1'b0;
      exp_inc_o <= 1'b0;
      zero_o    <= 1'b0;
      sext_o    <= 1'b0;
      tag_o     <= '0;
    end else if (flush_i) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_move || (s2_valid && !out_ready_i);
      if (s1_move) begin
        mant_o    <= n_mant;
        round_o   <= n_round;
        sticky_o  <= n_sticky;
        exp_inc_o <= n_exp_inc;
        zero_o    <= n_zero;
        sext_o    <= s1_sext;
        tag_o     <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_booth_product_normalizer.sv
// Scoreboard bench: the driver pushes model results on accept, an independent
// monitor pops and compares on every output handshake.
module tb_booth_product_normalizer;

  localparam int M  = 23;
  localparam int M1 = M + 1;
  localparam int T  = 10;
  localparam int W  = 2*M + 3;

  typedef struct packed {
    logic [M:0]   mant;
    logic         round;
    logic         sticky;
    logic         exp_inc;
    logic         zero;
    logic         sext;
    logic [T-1:0] tag;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         flush_i = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [W-1:0] wallace_sum_i = '0;
  logic [W-1:0] wallace_carry_i = '0;
  logic         suppression_sign_extension_i = 1'b0;
  logic [T-1:0] tag_i = '0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b1;
  logic [M:0]   mant_o;
  logic         round_o, sticky_o, exp_inc_o, zero_o, sext_o;
  logic [T-1:0] tag_o;

  int checks = 0;
  int failures = 0;
  res_t sb[$];

  booth_product_normalizer #(.PARM_MANT(M), .PARM_TAG(T)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .wallace_sum_i(wallace_sum_i), .wallace_carry_i(wallace_carry_i),
    .suppression_sign_extension_i(suppression_sign_extension_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .mant_o(mant_o), .round_o(round_o), .sticky_o(sticky_o),
    .exp_inc_o(exp_inc_o), .zero_o(zero_o), .sext_o(sext_o), .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  res_t dut_res;
  assign dut_res = '{mant: mant_o, round: round_o, sticky: sticky_o,
                     exp_inc: exp_inc_o, zero: zero_o, sext: sext_o, tag: tag_o};

  // Reference: plain integer arithmetic on the product value.
  function automatic res_t model(input logic [W-1:0] s, input logic [W-1:0] c,
                                 input logic f, input logic [T-1:0] t);
    logic [63:0] p;
    res_t r;
    p = ({{(64-W){1'b0}}, s} + ({{(64-W){1'b0}}, c} << 1)) & ((64'd1 << (W-1)) - 64'd1);
    r = '0;
    r.sext = f;
    r.tag  = t;
    if (p == 64'd0) begin
      r.zero = 1'b1;
    end else if ((p >> (2*M+1)) != 64'd0) begin
      r.mant    = M1'(p >> (M+1));
      r.round   = p[M];
      r.sticky  = (p & ((64'd1 << M) - 64'd1)) != 64'd0;
      r.exp_inc = 1'b1;
    end else begin
      r.mant   = M1'(p >> M);
      r.round  = p[M-1];
      r.sticky = (p & ((64'd1 << (M-1)) - 64'd1)) != 64'd0;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Present one operand (inputs change at negedge) and wait for acceptance.
  task automatic drive(input logic [W-1:0] s, input logic [W-1:0] c,
                       input logic f, input logic [T-1:0] t);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    wallace_sum_i = s;
    wallace_carry_i = c;
    suppression_sign_extension_i = f;
    tag_i = t;
    #1;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready_o) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout tag=%h", t);
    end else begin
      sb.push_back(model(s, c, f, t));
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic drive_rand();
    logic [W-1:0] s, c;
    logic [63:0] p;
    c = W'({$urandom, $urandom});
    if ($urandom_range(0, 1) == 0) begin
      s = W'({$urandom, $urandom});
    end else begin
      p = {16'd0, $urandom, 16'(($urandom))} >> $urandom_range(0, 47);
      s = W'(p) - (c << 1);
      s[W-1] = 1'(($urandom));
    end
    drive(s, c, 1'(($urandom)), T'($urandom));
  endtask

  // Monitor: pops on handshakes, and checks payload holds under backpressure.
  logic hold_pending = 1'b0;
  res_t held;
  int   popped = 0;
  always @(negedge clk) begin
    #1;
    if (hold_pending) begin
      check("hold_valid", 64'(out_valid_o), 64'd1);
      check("hold_payload", 64'(dut_res), 64'(held));
    end
    hold_pending = out_valid_o && !out_ready_i && !flush_i && !rst_i;
    held = dut_res;
    if (out_valid_o && out_ready_i && !flush_i && !rst_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output got=%h", dut_res);
      end else begin
        res_t e;
        e = sb.pop_front();
        checks++;
        if (dut_res !== e) begin
          failures++;
          $display("FAIL result#%0d got mant=%h r=%b s=%b ei=%b z=%b sx=%b tag=%h expected mant=%h r=%b s=%b ei=%b z=%b sx=%b tag=%h",
                   popped, mant_o, round_o, sticky_o, exp_inc_o, zero_o, sext_o, tag_o,
                   e.mant, e.round, e.sticky, e.exp_inc, e.zero, e.sext, e.tag);
        end
        popped++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] mx_p;
  bit done;

  initial begin
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid_o), 64'd0);
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
    check("reset_data", 64'(dut_res), 64'd0);
    @(negedge clk);

    // Directed corner cases
    drive(W'(1) << 46, '0, 1'b0, T'(1));
    mx_p = W'(48'hFFFFFE000001);
    drive(mx_p - W'(2 * 48'h123456), W'(48'h123456), 1'b1, T'(2));
    drive(W'(48'h000001FFFFFF), W'(48'h000000800000), 1'b0, T'(3));
    drive(W'(1) << 48, '0, 1'b1, T'(4));
    drive(W'(48'h000000000001), '0, 1'b0, T'(5));
    repeat (4) @(negedge clk);

    // Backpressure: ready low for four cycles mid-stream
    fork
      begin
        for (int i = 0; i < 5; i++) drive_rand();
      end
      begin
        out_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        out_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("bp_in_ready_low", 64'(in_ready_o), 64'd0);
        check("bp_out_valid", 64'(out_valid_o), 64'd1);
        @(negedge clk);
        out_ready_i = 1'b1;
      end
    join
    repeat (4) @(negedge clk);

    // Random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) drive_rand();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready_i = $urandom_range(0, 3) != 0;
        end
      end
    join
    out_ready_i = 1'b1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);

    // Flush with both stages full and a simultaneous accepting input
    out_ready_i = 1'b0;
    drive_rand();
    drive_rand();
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready_o), 64'd1);
    @(negedge clk);
    sb.delete();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("flush_no_valid", 64'(out_valid_o), 64'd0);
      @(negedge clk);
    end

    // Reset in the same situation
    out_ready_i = 1'b0;
    drive_rand();
    drive_rand();
    rst_i = 1'b1;
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    sb.delete();
    rst_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_data", 64'(dut_res), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rst_no_valid", 64'(out_valid_o), 64'd0);
    end

    // Pipeline still works after reset
    drive(W'(1) << 46, '0, 1'b1, T'(9));
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
